// File: rtl/alu_pkg.sv
// Shared definitions for the ALU initiator slice.
// Contents:
//   OPND_W / RES_W / OP_W - operand, result and opcode widths
//   alu_op_e              - ALU opcode encoding (6 and 7 are unused/illegal)
//   is_legal_op()         - true for opcodes the ALU implements
package alu_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_MUL  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOTA = 3'd5
  } alu_op_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_NOTA);
  endfunction

endpackage

// File: rtl/alu_master_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Ports:
//   CLK, rst_n        - clock, asynchronous active-low reset (empties FIFO)
//   push / wr_data    - write request and data; ignored when full unless a
//                       pop happens on the same edge
//   pop  / rd_data    - read request; rd_data shows the head entry
//   full, empty       - derived from count
//   count             - number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A write into a full FIFO is accepted when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_master.sv
// alu_master: initiator for the unsigned 8-bit registered ALU.
// Buffers tagged commands, issues at most one per cycle to the ALU while the
// response FIFO has room for every outstanding result, captures the ALU
// result two edges after issue and returns responses in command order.
// Ports:
//   CLK, rst_n                     - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            - command handshake
//   cmd_a, cmd_b, cmd_op, cmd_tag  - command payload
//   alu_en, alu_a, alu_b, alu_op   - registered drive to the ALU
//   alu_result                     - ALU registered 16-bit result
//   rsp_valid/rsp_ready            - response handshake
//   rsp_result, rsp_tag, rsp_err   - response payload (zero while empty)
//   busy                           - anything queued, in flight or pending
module alu_master
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              alu_en,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CMD_W  = 2*OPND_W + OP_W + TAG_W;
  localparam int RSP_W  = RES_W + TAG_W + 1;
  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
  localparam int SUM_W  = RSP_CW + 1;

  logic [CMD_W-1:0]  cmd_rd_data;
  logic              cmd_full;
  logic              cmd_empty;
  logic [CMD_CW-1:0] cmd_count;
  logic              cmd_push;

  logic [RSP_W-1:0]  rsp_wr_data;
  logic [RSP_W-1:0]  rsp_rd_data;
  logic              rsp_full;
  logic              rsp_empty;
  logic [RSP_CW-1:0] rsp_count;
  logic              rsp_pop;

  logic [OPND_W-1:0] hd_a;
  logic [OPND_W-1:0] hd_b;
  logic [OP_W-1:0]   hd_op;
  logic [TAG_W-1:0]  hd_tag;
  logic              hd_legal;

  logic [1:0]        inflight;
  logic [SUM_W-1:0]  pending;
  logic              credit_ok;
  logic              issue;

  logic              vld_p0;
  logic [TAG_W-1:0]  tag_p0;
  logic              err_p0;
  logic              vld_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic              err_p1;
  logic [RES_W-1:0]  cap_result;

  // The full flags / count not needed for control are tied off here.
  logic              unused_flags;
  assign unused_flags = &{1'b0, rsp_full, cmd_count};

  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_ready = !cmd_full;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .push    (cmd_push),
    .wr_data ({cmd_a, cmd_b, cmd_op, cmd_tag}),
    .pop     (issue),
    .rd_data (cmd_rd_data),
    .full    (cmd_full),
    .empty   (cmd_empty),
    .count   (cmd_count)
  );

  assign {hd_a, hd_b, hd_op, hd_tag} = cmd_rd_data;
  assign hd_legal = is_legal_op(hd_op);

  // Every issued slot owns a response FIFO entry from issue until popped, so
  // the capture stage can never find the response FIFO full.
  assign inflight  = {1'b0, vld_p0} + {1'b0, vld_p1};
  assign pending   = SUM_W'(rsp_count) + SUM_W'(inflight);
  assign credit_ok = (pending < SUM_W'(RSP_DEPTH));
  assign issue     = !cmd_empty && credit_ok;

  // ---- stage p0: issue edge, ALU inputs registered ----
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      alu_en <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else begin
      vld_p0 <= issue;
      // Illegal opcodes occupy a pipeline slot but never reach the ALU.
      alu_en <= issue && hd_legal;
      if (issue && hd_legal) begin
        alu_a  <= hd_a;
        alu_b  <= hd_b;
        alu_op <= hd_op;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) begin
      tag_p0 <= hd_tag;
      err_p0 <= !hd_legal;
    end
  end

  // ---- stage p1: ALU samples its inputs ----
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge CLK) begin
    tag_p1 <= tag_p0;
    err_p1 <= err_p0;
  end

  // ---- stage p2: ALU result captured into the response FIFO ----
  assign cap_result  = err_p1 ? '0 : alu_result;
  assign rsp_wr_data = {cap_result, tag_p1, err_p1};
  assign rsp_pop     = rsp_valid && rsp_ready;

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .push    (vld_p1),
    .wr_data (rsp_wr_data),
    .pop     (rsp_pop),
    .rd_data (rsp_rd_data),
    .full    (rsp_full),
    .empty   (rsp_empty),
    .count   (rsp_count)
  );

  assign rsp_valid = !rsp_empty;
  // Payload forced to zero while empty so unwritten storage never shows.
  assign {rsp_result, rsp_tag, rsp_err} = rsp_valid ? rsp_rd_data : '0;

  assign busy = !cmd_empty || vld_p0 || vld_p1 || !rsp_empty;

endmodule

// File: tb/tb_alu_master.sv
module tb_alu_master;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic        alu_en;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [15:0] res;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  tag;
    logic        err;
  } rsp_t;

  rsp_t rsp_q[$];
  bit   en_q[$];
  int   en_cnt = 0;

  always #5 CLK = ~CLK;

  alu_master #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_en     (alu_en),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Registered ALU: samples en/A/B/OP on the edge after they are driven.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) alu_result <= '0;
    else if (alu_en) begin
      case (alu_op)
        3'd0:    alu_result <= {8'h00, alu_a} + {8'h00, alu_b};
        3'd1:    alu_result <= 16'(alu_a) * 16'(alu_b);
        3'd2:    alu_result <= {8'h00, alu_a & alu_b};
        3'd3:    alu_result <= {8'h00, alu_a | alu_b};
        3'd4:    alu_result <= {8'h00, alu_a ^ alu_b};
        3'd5:    alu_result <= {8'h00, ~alu_a};
        default: alu_result <= '0;
      endcase
    end
  end

  // Monitor on the falling edge: inputs only change just after rising edges.
  always @(negedge CLK) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_result, rsp_tag, rsp_err});
      en_q.push_back(alu_en);
      if (alu_en) en_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    logic acc;
    int   n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      acc = cmd_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(input int target, input int max_cyc);
    int c;
    c = 0;
    while (rsp_q.size() < target && c < max_cyc) begin
      @(posedge CLK);
      #1;
      c++;
    end
    check("rsp_arrivals", 32'(rsp_q.size()), 32'(target));
  endtask

  vec_t tbl[9];

  initial begin
    int base;
    int en_base;
    int first;
    int k;
    int idx;
    logic acc;

    tbl[0] = '{8'hFF, 8'hFF, 3'd1, 4'd1, 16'hFE01, 1'b0};
    tbl[1] = '{8'h0F, 8'h00, 3'd5, 4'd2, 16'h00F0, 1'b0};
    tbl[2] = '{8'hAA, 8'h0F, 3'd4, 4'd3, 16'h00A5, 1'b0};
    tbl[3] = '{8'h01, 8'h01, 3'd0, 4'd4, 16'h0002, 1'b0};
    tbl[4] = '{8'h12, 8'h34, 3'd6, 4'd5, 16'h0000, 1'b1};
    tbl[5] = '{8'h30, 8'h03, 3'd3, 4'd6, 16'h0033, 1'b0};
    tbl[6] = '{8'hF0, 8'h3C, 3'd2, 4'd7, 16'h0030, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 3'd7, 4'd8, 16'h0000, 1'b1};
    tbl[8] = '{8'hFF, 8'hFF, 3'd0, 4'd9, 16'h01FE, 1'b0};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    cyc(3);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_en",    32'(alu_en),    32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Minimum latency: ADD 200+100 tag 3.
    rsp_ready = 1'b1;
    cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = 3'd0; cmd_tag = 4'd3;
    cmd_valid = 1'b1;
    cyc(1);                       // edge 0: accepted
    cmd_valid = 1'b0;
    check("lat_en_e0", 32'(alu_en), 32'd0);
    cyc(1);                       // edge 1: issued
    check("lat_en_e1", 32'(alu_en), 32'd1);
    check("lat_alu_a", 32'(alu_a),  32'd200);
    check("lat_alu_b", 32'(alu_b),  32'd100);
    check("lat_alu_op", 32'(alu_op), 32'd0);
    cyc(1);                       // edge 2
    check("lat_en_e2",    32'(alu_en),    32'd0);
    check("lat_valid_e2", 32'(rsp_valid), 32'd0);
    cyc(1);                       // edge 3: captured
    check("lat_valid_e3", 32'(rsp_valid),  32'd1);
    check("lat_result",   32'(rsp_result), 32'h012C);
    check("lat_tag",      32'(rsp_tag),    32'd3);
    check("lat_err",      32'(rsp_err),    32'd0);
    cyc(3);
    check("lat_idle_busy", 32'(busy), 32'd0);

    // Table vectors back-to-back: order, illegal-op handling, enable pattern.
    base    = rsp_q.size();
    en_base = en_q.size();
    for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag);
    wait_rsp(base + 9, 100);
    for (int i = 0; i < 9; i++) begin
      idx = base + i;
      if (idx < rsp_q.size()) begin
        check($sformatf("tbl%0d_result", i), 32'(rsp_q[idx].res), 32'(tbl[i].res));
        check($sformatf("tbl%0d_tag", i),    32'(rsp_q[idx].tag), 32'(tbl[i].tag));
        check($sformatf("tbl%0d_err", i),    32'(rsp_q[idx].err), 32'(tbl[i].err));
      end
    end
    first = -1;
    for (int i = en_base; i < en_q.size(); i++) begin
      if (first < 0 && en_q[i]) first = i;
    end
    check("tbl_en_seen", 32'(first >= 0), 32'd1);
    if (first >= 0) begin
      for (int i = 0; i < 9; i++) begin
        idx = first + i;
        check($sformatf("tbl%0d_en_slot", i),
              32'((idx < en_q.size()) ? en_q[idx] : 1'b0), 32'(!tbl[i].err));
      end
    end

    // Backpressure: rsp_ready low, offer 10 commands.
    rsp_ready = 1'b0;
    cyc(2);
    en_base = en_cnt;
    k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      cmd_a = 8'(10 * k); cmd_b = 8'd3; cmd_op = 3'd0; cmd_tag = 4'(k);
      cmd_valid = 1'b1;
      acc = cmd_ready;
      @(posedge CLK);
      #1;
      if (acc) k++;
    end
    cmd_valid = 1'b0;
    check("bp_accepted",  32'(k),              32'd8);
    check("bp_cmd_ready", 32'(cmd_ready),      32'd0);
    check("bp_busy",      32'(busy),           32'd1);
    check("bp_issues",    32'(en_cnt - en_base), 32'd4);
    check("bp_hold_res0", 32'(rsp_result),     32'd3);
    cyc(3);
    check("bp_hold_res1", 32'(rsp_result),     32'd3);
    check("bp_hold_tag",  32'(rsp_tag),        32'd0);
    check("bp_hold_val",  32'(rsp_valid),      32'd1);
    base = rsp_q.size();
    rsp_ready = 1'b1;
    wait_rsp(base + 8, 100);
    for (int i = 0; i < 8; i++) begin
      idx = base + i;
      if (idx < rsp_q.size()) begin
        check($sformatf("bp%0d_result", i), 32'(rsp_q[idx].res), 32'(10 * i + 3));
        check($sformatf("bp%0d_tag", i),    32'(rsp_q[idx].tag), 32'(i));
      end
    end
    check("bp_total_issues", 32'(en_cnt - en_base), 32'd8);

    // Reset mid-stream with work queued and in flight.
    rsp_ready = 1'b0;
    send(8'd1, 8'd2, 3'd0, 4'd1);
    send(8'd3, 8'd4, 3'd0, 4'd2);
    cyc(1);
    for (int i = 0; i < 5; i++) send(8'(i), 8'd1, 3'd1, 4'(i + 3));
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_en",    32'(alu_en),     32'd0);
    check("mid_rst_alu_a",     32'(alu_a),      32'd0);
    check("mid_rst_alu_b",     32'(alu_b),      32'd0);
    check("mid_rst_alu_op",    32'(alu_op),     32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid),  32'd0);
    check("mid_rst_rsp_res",   32'(rsp_result), 32'd0);
    check("mid_rst_busy",      32'(busy),       32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy",      32'(busy),      32'd0);
    base = rsp_q.size();
    rsp_ready = 1'b1;
    send(8'd5, 8'd6, 3'd0, 4'd10);
    wait_rsp(base + 1, 20);
    cyc(10);
    check("post_rst_rsp_cnt", 32'(rsp_q.size() - base), 32'd1);
    if (base < rsp_q.size()) begin
      check("post_rst_result", 32'(rsp_q[base].res), 32'h000B);
      check("post_rst_tag",    32'(rsp_q[base].tag), 32'd10);
      check("post_rst_err",    32'(rsp_q[base].err), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
